// File: rtl/buffer_resultados_if.sv
// Result-buffer bus: adder-side write strobe/data,
// consumer-side read request and buffer status.
interface buffer_resultados_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 2
);
  logic             ENB_IN;
  logic [WIDTH-1:0] Q_IN;
  logic             RCO_IN;
  logic             RD;
  logic [WIDTH:0]   DATA_OUT;
  logic             VALID_OUT;
  logic             EMPTY;
  logic             FULL;
  logic [ADDR:0]    COUNT;
  logic             OVERFLOW;
  logic [7:0]       RCO_CNT;

  modport master (
    output ENB_IN, Q_IN, RCO_IN, RD,
    input  DATA_OUT, VALID_OUT, EMPTY, FULL,
    input  COUNT, OVERFLOW, RCO_CNT
  );

  modport slave (
    input  ENB_IN, Q_IN, RCO_IN, RD,
    output DATA_OUT, VALID_OUT, EMPTY, FULL,
    output COUNT, OVERFLOW, RCO_CNT
  );
endinterface

// File: rtl/buffer_resultados.sv
// First-word-fall-through result FIFO behind the adder,
// with saturating carry count and sticky drop flag.
module buffer_resultados #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ADDR  = 2
) (
  input logic CLK,
  input logic RESET,
  buffer_resultados_if.slave bus
);
  localparam logic [ADDR:0]   FULL_C = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0]   CNT_1  = (ADDR+1)'(1);
  localparam logic [ADDR-1:0] PTR_1  = ADDR'(1);

  logic [WIDTH:0]    mem [DEPTH];
  logic [ADDR-1:0]   rd_ptr;
  logic [ADDR-1:0]   wr_ptr;
  logic [ADDR:0]     count;
  logic              overflow;
  logic [7:0]        rco_cnt;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;

  // Handshake qualification: a full buffer still
  // accepts a word when the head leaves the same cycle.
  always_comb begin
    empty = (count == '0);
    full  = (count == FULL_C);
    pop   = bus.RD && !empty;
    push  = bus.ENB_IN && (!full || pop);
  end

  // Storage array; contents need no reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {bus.RCO_IN, bus.Q_IN};
  end

  // Pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_1;
      if (push) wr_ptr <= wr_ptr + PTR_1;
      if (push && !pop)      count <= count + CNT_1;
      else if (pop && !push) count <= count - CNT_1;
    end
  end

  // Sticky drop flag and saturating carry counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      overflow <= 1'b0;
      rco_cnt  <= '0;
    end else begin
      if (bus.ENB_IN && !push) overflow <= 1'b1;
      if (push && bus.RCO_IN && rco_cnt != 8'hFF)
        rco_cnt <= rco_cnt + 8'd1;
    end
  end

  // Outputs from registered state only.
  always_comb begin
    bus.DATA_OUT  = empty ? '0 : mem[rd_ptr];
    bus.VALID_OUT = !empty;
    bus.EMPTY     = empty;
    bus.FULL      = full;
    bus.COUNT     = count;
    bus.OVERFLOW  = overflow;
    bus.RCO_CNT   = rco_cnt;
  end
endmodule

// File: tb/tb_buffer_resultados.sv
// Bench for buffer_resultados: directed scenarios plus
// random traffic against a queue-based reference.
module tb_buffer_resultados;
  logic CLK = 1'b0;
  logic RESET;
  int   errs = 0;
  int   chks = 0;

  logic [8:0] mq [$];
  int         mrco;
  bit         movf;

  buffer_resultados_if #(.WIDTH(8), .ADDR(2)) bus ();

  buffer_resultados #(.WIDTH(8), .DEPTH(4), .ADDR(2)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic chk_all();
    logic [8:0] hd;
    hd = (mq.size() > 0) ? mq[0] : 9'h000;
    chk("data",  32'(bus.DATA_OUT), 32'(hd));
    chk("valid", 32'(bus.VALID_OUT), 32'(mq.size() > 0));
    chk("empty", 32'(bus.EMPTY), 32'(mq.size() == 0));
    chk("full",  32'(bus.FULL), 32'(mq.size() == 4));
    chk("count", 32'(bus.COUNT), 32'(mq.size()));
    chk("ovf",   32'(bus.OVERFLOW), 32'(movf));
    chk("rcocnt", 32'(bus.RCO_CNT), 32'(mrco));
  endtask

  task automatic step(input bit rst, input bit enb,
                      input logic [7:0] q, input bit rco,
                      input bit rd);
    bit p_pop;
    bit p_push;
    @(negedge CLK);
    RESET      = rst;
    bus.ENB_IN = enb;
    bus.Q_IN   = q;
    bus.RCO_IN = rco;
    bus.RD     = rd;
    @(posedge CLK);
    if (rst) begin
      mq.delete();
      mrco = 0;
      movf = 0;
    end else begin
      p_pop  = rd && mq.size() > 0;
      p_push = enb && (mq.size() < 4 || p_pop);
      if (p_pop) void'(mq.pop_front());
      if (p_push) begin
        mq.push_back({rco, q});
        if (rco && mrco < 255) mrco++;
      end
      if (enb && !p_push) movf = 1;
    end
    #1;
    chk_all();
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0);
  endtask

  task automatic rst_cyc();
    step(1, 0, 8'h00, 0, 0);
  endtask

  initial begin
    RESET      = 1'b1;
    bus.ENB_IN = 1'b0;
    bus.Q_IN   = '0;
    bus.RCO_IN = 1'b0;
    bus.RD     = 1'b0;
    mrco = 0;
    movf = 0;

    rst_cyc();
    rst_cyc();
    idle();
    idle();
    chk("rst_data", 32'(bus.DATA_OUT), 32'h000);
    chk("rst_empty", 32'(bus.EMPTY), 32'd1);

    step(0, 1, 8'h12, 0, 0);
    step(0, 1, 8'hFF, 1, 0);
    chk("t2_head0", 32'(bus.DATA_OUT), 32'h012);
    step(0, 0, 8'h00, 0, 1);
    chk("t2_head1", 32'(bus.DATA_OUT), 32'h1FF);
    step(0, 0, 8'h00, 0, 1);
    chk("t2_cnt", 32'(bus.COUNT), 32'd0);
    chk("t2_rco", 32'(bus.RCO_CNT), 32'd1);
    step(0, 0, 8'h00, 0, 1);

    rst_cyc();
    for (int i = 1; i <= 5; i++)
      step(0, 1, 8'(i), 0, 0);
    chk("t3_full", 32'(bus.FULL), 32'd1);
    chk("t3_ovf", 32'(bus.OVERFLOW), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_drain", 32'(bus.DATA_OUT), 32'(i));
      step(0, 0, 8'h00, 0, 1);
    end
    chk("t3_empty", 32'(bus.EMPTY), 32'd1);

    rst_cyc();
    for (int i = 0; i < 4; i++)
      step(0, 1, 8'($urandom), 1'($urandom), 0);
    step(0, 1, 8'hAA, 0, 1);
    chk("t4_cnt", 32'(bus.COUNT), 32'd4);
    chk("t4_ovf", 32'(bus.OVERFLOW), 32'd0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 8'h00, 0, 1);
    chk("t4_last", 32'(bus.DATA_OUT), 32'h0AA);
    step(0, 0, 8'h00, 0, 1);

    rst_cyc();
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'($urandom), 1'($urandom), i >= 1);
      chk("t5_le2", 32'(bus.COUNT <= 3'd2), 32'd1);
    end
    step(0, 0, 8'h00, 0, 1);
    step(0, 0, 8'h00, 0, 1);

    rst_cyc();
    for (int i = 0; i < 300; i++)
      step(0, 1, 8'($urandom), 1, 1);
    chk("t6_sat", 32'(bus.RCO_CNT), 32'd255);
    step(1, 1, 8'h55, 1, 1);
    chk("t6_empty", 32'(bus.EMPTY), 32'd1);
    chk("t6_rco0", 32'(bus.RCO_CNT), 32'd0);
    chk("t6_ovf0", 32'(bus.OVERFLOW), 32'd0);

    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) == 0), 1'($urandom),
           8'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0));

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
